// File: rtl/tl_cmd_if.sv
// Command-port bundle between the two requesters, the arbiter and the traffic-light controller.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface tl_cmd_if #(
   parameter int DATA_W = 16
) ();
   logic              s0_valid_i;
   logic              s0_ready_o;
   logic [2:0]        s0_cmd_type_i;
   logic [DATA_W-1:0] s0_cmd_data_i;
   logic              s1_valid_i;
   logic              s1_ready_o;
   logic [2:0]        s1_cmd_type_i;
   logic [DATA_W-1:0] s1_cmd_data_i;
   logic              cmd_valid_o;
   logic [2:0]        cmd_type_o;
   logic [DATA_W-1:0] cmd_data_o;
   logic              remote_locked_o;
   logic              bad_cmd_o;
   logic              rej_o;
   logic              busy_o;

   modport slave (
      input  s0_valid_i, s0_cmd_type_i, s0_cmd_data_i,
      input  s1_valid_i, s1_cmd_type_i, s1_cmd_data_i,
      output s0_ready_o, s1_ready_o,
      output cmd_valid_o, cmd_type_o, cmd_data_o,
      output remote_locked_o, bad_cmd_o, rej_o, busy_o
   );

   modport master (
      output s0_valid_i, s0_cmd_type_i, s0_cmd_data_i,
      output s1_valid_i, s1_cmd_type_i, s1_cmd_data_i,
      input  s0_ready_o, s1_ready_o,
      input  cmd_valid_o, cmd_type_o, cmd_data_o,
      input  remote_locked_o, bad_cmd_o, rej_o, busy_o
   );
endinterface

// File: rtl/tl_cmd_arbiter.sv
// Round-robin arbiter sharing the traffic-light command port between the local panel (s0)
// and the remote link (s1), with a guard gap after each command and a remote lockout.
module tl_cmd_arbiter #(
   parameter int DATA_W     = 16,
   parameter int GAP_CYCLES = 4
) (
   input  logic     clk_i,
   input  logic     srst_n_i,
   tl_cmd_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2,
      DROP  = 2'd3
   } state_t;

   localparam logic [2:0] TYPE_TURN_ON  = 3'd0;
   localparam logic [2:0] TYPE_TURN_OFF = 3'd1;
   localparam logic [2:0] TYPE_ILLEGAL  = 3'd6;
   localparam logic [7:0] GAP_LOAD      = 8'(GAP_CYCLES);

   state_t            state_q, state_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              lock_q, lock_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [2:0]        cmd_type_q, cmd_type_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic              bad_q, bad_d;
   logic              rej_q, rej_d;
   logic              busy_q, busy_d;

   logic              idle;
   logic              grant_s0;
   logic              grant_s1;
   logic              accept;
   logic [2:0]        sel_type;
   logic [DATA_W-1:0] sel_data;

   // Ties go to the requester that did not win last; reset leaves s1 as last winner.
   always_comb begin
      idle     = (state_q == IDLE) && srst_n_i;
      grant_s0 = idle && bus.s0_valid_i && (!bus.s1_valid_i || last_grant_q);
      grant_s1 = idle && bus.s1_valid_i && (!bus.s0_valid_i || !last_grant_q);
      accept   = grant_s0 || grant_s1;
      sel_type = grant_s1 ? bus.s1_cmd_type_i : bus.s0_cmd_type_i;
      sel_data = grant_s1 ? bus.s1_cmd_data_i : bus.s0_cmd_data_i;
   end

   always_comb begin
      state_d      = state_q;
      gap_cnt_d    = gap_cnt_q;
      last_grant_d = last_grant_q;
      lock_d       = lock_q;
      cmd_valid_d  = 1'b0;
      cmd_type_d   = cmd_type_q;
      cmd_data_d   = cmd_data_q;
      bad_d        = 1'b0;
      rej_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               last_grant_d = grant_s1;
               if (sel_type >= TYPE_ILLEGAL) begin
                  bad_d   = 1'b1;
                  state_d = DROP;
               end else if (grant_s1 && lock_q) begin
                  rej_d   = 1'b1;
                  state_d = DROP;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_type_d  = sel_type;
                  cmd_data_d  = sel_data;
                  state_d     = ISSUE;
                  // Only the local panel may lock or unlock the remote link.
                  if (grant_s0 && (sel_type == TYPE_TURN_OFF)) lock_d = 1'b1;
                  if (grant_s0 && (sel_type == TYPE_TURN_ON))  lock_d = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (GAP_CYCLES == 0) begin
               state_d = IDLE;
            end else begin
               state_d   = GAP;
               gap_cnt_d = GAP_LOAD;
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - 8'd1;
            if (gap_cnt_q <= 8'd1) state_d = IDLE;
         end
         DROP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q      <= IDLE;
         gap_cnt_q    <= 8'd0;
         last_grant_q <= 1'b1;
         lock_q       <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_type_q   <= 3'd0;
         cmd_data_q   <= '0;
         bad_q        <= 1'b0;
         rej_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         last_grant_q <= last_grant_d;
         lock_q       <= lock_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_type_q   <= cmd_type_d;
         cmd_data_q   <= cmd_data_d;
         bad_q        <= bad_d;
         rej_q        <= rej_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.s0_ready_o      = grant_s0;
   assign bus.s1_ready_o      = grant_s1;
   assign bus.cmd_valid_o     = cmd_valid_q;
   assign bus.cmd_type_o      = cmd_type_q;
   assign bus.cmd_data_o      = cmd_data_q;
   assign bus.remote_locked_o = lock_q;
   assign bus.bad_cmd_o       = bad_q;
   assign bus.rej_o           = rej_q;
   assign bus.busy_o          = busy_q;

endmodule

// File: tb/tb_tl_cmd_arbiter.sv
// Directed bench for tl_cmd_arbiter: a negedge scoreboard predicts the outcome of every accepted
// request, while the main sequence checks grant order, spacing, lockout, drops and reset.
module tb_tl_cmd_arbiter;

   logic clk = 1'b0;
   logic srst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tl_cmd_if #(.DATA_W(16)) bus  ();
   tl_cmd_if #(.DATA_W(16)) bus2 ();

   tl_cmd_arbiter #(.DATA_W(16), .GAP_CYCLES(4)) dut  (.clk_i(clk), .srst_n_i(srst_n), .bus(bus));
   tl_cmd_arbiter #(.DATA_W(16), .GAP_CYCLES(0)) dut0 (.clk_i(clk), .srst_n_i(srst_n), .bus(bus2));

   typedef struct {
      int          kind;   // 0 forwarded, 1 bad type, 2 rejected by lock
      logic [2:0]  t;
      logic [15:0] d;
   } exp_t;

   exp_t        sb[$];
   logic        lock_m = 1'b0;
   logic [2:0]  last_t = 3'd0;
   logic [15:0] last_d = 16'd0;
   bit          mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void predict(input int src, input logic [2:0] t, input logic [15:0] d);
      exp_t e;
      e.t = t;
      e.d = d;
      if (t >= 3'd6)               e.kind = 1;
      else if (src == 1 && lock_m) e.kind = 2;
      else begin
         e.kind = 0;
         if (src == 0 && t == 3'd1) lock_m = 1'b1;
         if (src == 0 && t == 3'd0) lock_m = 1'b0;
      end
      sb.push_back(e);
   endfunction

   // Scoreboard: an accept seen in cycle N is resolved against the outputs of cycle N+1.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit   has;
         has = (sb.size() > 0);
         if (has) e = sb.pop_front();
         chk("sb_strobe", bus.cmd_valid_o, has && e.kind == 0);
         chk("sb_bad", bus.bad_cmd_o, has && e.kind == 1);
         chk("sb_rej", bus.rej_o, has && e.kind == 2);
         if (has && e.kind == 0) begin
            last_t = e.t;
            last_d = e.d;
         end
         chk("sb_type", bus.cmd_type_o, last_t);
         chk("sb_data", bus.cmd_data_o, last_d);
         chk("sb_lock", bus.remote_locked_o, lock_m);
         chk("sb_one_ready", bus.s0_ready_o & bus.s1_ready_o, 1'b0);
         if (!srst_n) begin
            lock_m = 1'b0;
            last_t = 3'd0;
            last_d = 16'd0;
         end else if (bus.s0_valid_i && bus.s0_ready_o) begin
            predict(0, bus.s0_cmd_type_i, bus.s0_cmd_data_i);
         end else if (bus.s1_valid_i && bus.s1_ready_o) begin
            predict(1, bus.s1_cmd_type_i, bus.s1_cmd_data_i);
         end
      end
   end

   // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
   task automatic send(input int src, input logic [2:0] t, input logic [15:0] d, output int acc);
      acc = -1;
      if (src == 0) begin
         bus.s0_valid_i = 1'b1; bus.s0_cmd_type_i = t; bus.s0_cmd_data_i = d;
      end else begin
         bus.s1_valid_i = 1'b1; bus.s1_cmd_type_i = t; bus.s1_cmd_data_i = d;
      end
      for (int i = 0; i < 64; i++) begin
         #1;
         if ((src == 0) ? bus.s0_ready_o : bus.s1_ready_o) begin
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      chk("accept_in_time", (acc >= 0), 1'b1);
      @(posedge clk); #1;
      if (src == 0) bus.s0_valid_i = 1'b0;
      else          bus.s1_valid_i = 1'b0;
   endtask

   initial begin
      int acc, acc2, n;
      int g[6];
      int c[6];
      int sc[10];

      bus.s0_valid_i = 1'b0; bus.s0_cmd_type_i = 3'd0; bus.s0_cmd_data_i = 16'd0;
      bus.s1_valid_i = 1'b0; bus.s1_cmd_type_i = 3'd0; bus.s1_cmd_data_i = 16'd0;
      bus2.s0_valid_i = 1'b0; bus2.s0_cmd_type_i = 3'd0; bus2.s0_cmd_data_i = 16'd0;
      bus2.s1_valid_i = 1'b0; bus2.s1_cmd_type_i = 3'd0; bus2.s1_cmd_data_i = 16'd0;

      srst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("rst_cmd_valid", bus.cmd_valid_o, 1'b0);
      chk("rst_type", bus.cmd_type_o, 3'd0);
      chk("rst_data", bus.cmd_data_o, 16'd0);
      chk("rst_lock", bus.remote_locked_o, 1'b0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_bad", bus.bad_cmd_o, 1'b0);
      chk("rst_rej", bus.rej_o, 1'b0);
      chk("rst_ready0", bus.s0_ready_o, 1'b0);
      chk("rst_ready1", bus.s1_ready_o, 1'b0);
      srst_n = 1'b1;

      // Single local command, then the earliest following accept.
      send(0, 3'd4, 16'h1234, acc);
      chk("t1_strobe", bus.cmd_valid_o, 1'b1);
      chk("t1_type", bus.cmd_type_o, 3'd4);
      chk("t1_data", bus.cmd_data_o, 16'h1234);
      chk("t1_busy", bus.busy_o, 1'b1);
      send(0, 3'd2, 16'h0042, acc2);
      chk("t1_spacing", acc2 - acc, 6);

      // Both requesters valid continuously: s0 won last, so s1 leads the alternation.
      bus.s0_valid_i = 1'b1; bus.s0_cmd_type_i = 3'd3; bus.s0_cmd_data_i = 16'hA0A0;
      bus.s1_valid_i = 1'b1; bus.s1_cmd_type_i = 3'd4; bus.s1_cmd_data_i = 16'hB1B1;
      n = 0;
      for (int i = 0; i < 100 && n < 6; i++) begin
         #1;
         if (bus.s0_ready_o)      begin g[n] = 0; c[n] = cyc; n++; end
         else if (bus.s1_ready_o) begin g[n] = 1; c[n] = cyc; n++; end
         @(posedge clk); #1;
      end
      bus.s0_valid_i = 1'b0;
      bus.s1_valid_i = 1'b0;
      chk("t2_count", n, 6);
      chk("t2_first", g[0], 1);
      for (int i = 1; i < 6; i++) begin
         chk("t2_alternate", g[i], (g[i-1] == 0) ? 1 : 0);
         chk("t2_spacing", c[i] - c[i-1], 6);
      end

      // Local TURN_OFF locks the remote link; remote command is swallowed.
      send(0, 3'd1, 16'h0000, acc);
      chk("t3_locked", bus.remote_locked_o, 1'b1);
      send(1, 3'd3, 16'h0333, acc);
      chk("t3_rej", bus.rej_o, 1'b1);
      chk("t3_no_strobe", bus.cmd_valid_o, 1'b0);
      chk("t3_drop_busy", bus.busy_o, 1'b1);
      @(posedge clk); #1;
      chk("t3_idle_after_drop", bus.busy_o, 1'b0);
      send(0, 3'd0, 16'h0000, acc);
      chk("t3_unlocked", bus.remote_locked_o, 1'b0);
      send(1, 3'd3, 16'h0333, acc);
      chk("t3_fwd_strobe", bus.cmd_valid_o, 1'b1);
      chk("t3_fwd_type", bus.cmd_type_o, 3'd3);
      chk("t3_fwd_data", bus.cmd_data_o, 16'h0333);

      // Illegal type is dropped with no guard gap.
      send(1, 3'd7, 16'h0777, acc);
      chk("t4_bad", bus.bad_cmd_o, 1'b1);
      chk("t4_no_strobe", bus.cmd_valid_o, 1'b0);
      chk("t4_type_held", bus.cmd_type_o, 3'd3);
      send(1, 3'd5, 16'h0555, acc2);
      chk("t4_no_gap", acc2 - acc, 2);

      // Reset in the middle of the guard gap clears the lock.
      send(0, 3'd1, 16'h0011, acc);
      chk("t5_locked", bus.remote_locked_o, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("t5_in_gap", bus.busy_o, 1'b1);
      srst_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_gap_rst_busy", bus.busy_o, 1'b0);
      chk("t5_gap_rst_lock", bus.remote_locked_o, 1'b0);
      chk("t5_gap_rst_type", bus.cmd_type_o, 3'd0);
      chk("t5_gap_rst_data", bus.cmd_data_o, 16'd0);
      srst_n = 1'b1;

      // Reset while the strobe is out: s1 was last, yet s0 wins the first tie afterwards.
      send(1, 3'd5, 16'h5A5A, acc);
      chk("t5_s1_strobe", bus.cmd_valid_o, 1'b1);
      srst_n = 1'b0;
      bus.s0_valid_i = 1'b1; bus.s0_cmd_type_i = 3'd2; bus.s0_cmd_data_i = 16'h0C0C;
      bus.s1_valid_i = 1'b1; bus.s1_cmd_type_i = 3'd2; bus.s1_cmd_data_i = 16'h0D0D;
      @(posedge clk); #1;
      chk("t5_issue_rst_strobe", bus.cmd_valid_o, 1'b0);
      chk("t5_issue_rst_busy", bus.busy_o, 1'b0);
      chk("t5_issue_rst_data", bus.cmd_data_o, 16'd0);
      chk("t5_rst_ready0", bus.s0_ready_o, 1'b0);
      chk("t5_rst_ready1", bus.s1_ready_o, 1'b0);
      srst_n = 1'b1;
      #1;
      chk("t5_first_s0", bus.s0_ready_o, 1'b1);
      chk("t5_first_not_s1", bus.s1_ready_o, 1'b0);
      @(posedge clk); #1;
      bus.s0_valid_i = 1'b0;
      bus.s1_valid_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Zero-gap build: a continuously valid s0 gets a strobe every other cycle.
      bus2.s0_valid_i = 1'b1; bus2.s0_cmd_type_i = 3'd4; bus2.s0_cmd_data_i = 16'hBEEF;
      n = 0;
      for (int i = 0; i < 60 && n < 10; i++) begin
         @(posedge clk); #1;
         if (bus2.cmd_valid_o) begin
            sc[n] = cyc;
            n++;
            chk("t6_data", bus2.cmd_data_o, 16'hBEEF);
         end
      end
      bus2.s0_valid_i = 1'b0;
      chk("t6_count", n, 10);
      for (int i = 1; i < 10; i++) chk("t6_spacing", sc[i] - sc[i-1], 2);

      repeat (10) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
